// File: rtl/branch_pred_pkg.sv
// Shared encodings for the branch prediction unit: 2-bit counter states,
// PC step and the JAL/JALR encoding of the EX-stage branch select field.
package branch_pred_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [31:0] PC_INCREMENT = 32'd4;
  localparam logic [3:0]  JUMP_SELECT  = 4'b1010;

  // True when an EX-stage branch select field denotes JAL/JALR.
  function automatic logic is_jump_select(input logic [3:0] sel);
    return sel == JUMP_SELECT;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
// force_strong_i jumps straight to strongly-taken (unconditional jumps).
module bp_sat_counter
  import branch_pred_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  input  logic       force_strong_i,
  output logic [1:0] next_o
);

  // Saturating increment on taken, decrement on not-taken.
  always_comb begin
    next_o = cur_i;
    if (force_strong_i) begin
      next_o = ST;
    end else if (taken_i) begin
      if (cur_i != ST) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != SNT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_prediction_unit.sv
// Fetch-side predictor: direct-mapped BTB with 2-bit counters, trained by
// EX-stage resolutions. A mispredicted resolution produces a registered
// one-cycle FLUSH with the corrected REDIRECT_PC. Resolutions arriving while
// FLUSH is high belong to the wrong path and are discarded.
module branch_prediction_unit
  import branch_pred_pkg::*;
#(
  parameter int ENTRIES    = 64,
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC_IF,
  output logic                 PREDICT_TAKEN,
  output logic [31:0]          PREDICT_TARGET,
  input  logic                 RES_VALID,
  input  logic                 RES_IS_JUMP,
  input  logic [31:0]          RES_PC,
  input  logic                 RES_TAKEN,
  input  logic [31:0]          RES_TARGET,
  input  logic                 RES_PRED_TAKEN,
  input  logic [31:0]          RES_PRED_TARGET,
  output logic                 FLUSH,
  output logic [31:0]          REDIRECT_PC,
  output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
  output logic [CNT_WIDTH-1:0] MISPRED_COUNT
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  // Prediction tables: valid/counter reset, tag/target need no reset.
  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic                 flush_q, flush_d;
  logic [31:0]          redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

  // Lookup side.
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic                  if_hit;

  // Resolution side.
  logic [INDEX_BITS-1:0] res_idx;
  logic [TAG_BITS-1:0]   res_tag;
  logic                  res_hit;
  logic                  accept;
  logic                  mispredict;
  logic [1:0]            ctr_upd;
  logic                  ctr_wr_en;
  logic [1:0]            ctr_wr_val;
  logic                  alloc;
  logic                  tgt_wr;

  // Zero-latency lookup from registered arrays; no bypass of same-cycle training.
  always_comb begin
    if_idx         = PC_IF[INDEX_BITS+1:2];
    if_tag         = PC_IF[31:INDEX_BITS+2];
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    PREDICT_TAKEN  = if_hit && ctr_q[if_idx][1];
    PREDICT_TARGET = PREDICT_TAKEN ? target_q[if_idx] : PC_IF + PC_INCREMENT;
  end

  bp_sat_counter u_sat_counter (
    .cur_i          (ctr_q[res_idx]),
    .taken_i        (RES_TAKEN),
    .force_strong_i (RES_IS_JUMP),
    .next_o         (ctr_upd)
  );

  // Decode the resolution: accept filter, mispredict detection, table write controls.
  always_comb begin
    res_idx    = RES_PC[INDEX_BITS+1:2];
    res_tag    = RES_PC[31:INDEX_BITS+2];
    res_hit    = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    accept     = RES_VALID && !flush_q;
    mispredict = accept && ((RES_TAKEN != RES_PRED_TAKEN) ||
                            (RES_TAKEN && (RES_TARGET != RES_PRED_TARGET)));
    // A hit always retrains the counter; a miss only allocates when taken.
    ctr_wr_en  = accept && (res_hit || RES_TAKEN);
    ctr_wr_val = res_hit ? ctr_upd : (RES_IS_JUMP ? ST : WT);
    alloc      = accept && !res_hit && RES_TAKEN;
    // Taken outcomes refresh the target on hit and fill it on allocation.
    tgt_wr     = accept && RES_TAKEN;
  end

  // Next-state for flush pulse, redirect address and saturating statistics.
  always_comb begin
    flush_d    = mispredict;
    redirect_d = redirect_q;
    if (mispredict) begin
      redirect_d = RES_TAKEN ? RES_TARGET : RES_PC + PC_INCREMENT;
    end
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (accept && (bcnt_q != '1))     bcnt_d = bcnt_q + CNT_WIDTH'(1);
    if (mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_WIDTH'(1);
  end

  // Valid bits and direction counters, cleared to invalid / weak not-taken.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else begin
      if (ctr_wr_en) ctr_q[res_idx]   <= ctr_wr_val;
      if (alloc)     valid_q[res_idx] <= 1'b1;
    end
  end

  // Tag and target storage; contents are meaningless until valid is set.
  always_ff @(posedge CLK) begin
    if (tgt_wr) begin
      target_q[res_idx] <= RES_TARGET;
      tag_q[res_idx]    <= res_tag;
    end
  end

  // Flush/redirect and statistics registers; reset drops any pending flush.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      bcnt_q     <= bcnt_d;
      mcnt_q     <= mcnt_d;
    end
  end

  assign FLUSH         = flush_q;
  assign REDIRECT_PC   = redirect_q;
  assign BRANCH_COUNT  = bcnt_q;
  assign MISPRED_COUNT = mcnt_q;

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Bench for branch_prediction_unit: table of resolution vectors with expected
// flush/redirect and follow-up prediction, plus hand sequences for the
// wrong-path filter, aliasing, wrap, counter saturation and mid-flush reset.
module tb_branch_prediction_unit;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [31:0]      PC_IF;
  logic             PREDICT_TAKEN;
  logic [31:0]      PREDICT_TARGET;
  logic             RES_VALID;
  logic             RES_IS_JUMP;
  logic [31:0]      RES_PC;
  logic             RES_TAKEN;
  logic [31:0]      RES_TARGET;
  logic             RES_PRED_TAKEN;
  logic [31:0]      RES_PRED_TARGET;
  logic             FLUSH;
  logic [31:0]      REDIRECT_PC;
  logic [CNT_W-1:0] BRANCH_COUNT;
  logic [CNT_W-1:0] MISPRED_COUNT;

  int n_vec = 0;
  int n_err = 0;

  // Expected {FLUSH, REDIRECT_PC} one cycle after each driven resolution.
  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic        jump;
    logic        taken;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic        exp_flush;
    logic [31:0] exp_redir;
    logic        exp_pt;
    logic [31:0] exp_ptgt;
  } vec_t;

  vec_t vecs[12];

  branch_prediction_unit #(
    .ENTRIES    (64),
    .INDEX_BITS (6),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .PC_IF           (PC_IF),
    .PREDICT_TAKEN   (PREDICT_TAKEN),
    .PREDICT_TARGET  (PREDICT_TARGET),
    .RES_VALID       (RES_VALID),
    .RES_IS_JUMP     (RES_IS_JUMP),
    .RES_PC          (RES_PC),
    .RES_TAKEN       (RES_TAKEN),
    .RES_TARGET      (RES_TARGET),
    .RES_PRED_TAKEN  (RES_PRED_TAKEN),
    .RES_PRED_TARGET (RES_PRED_TARGET),
    .FLUSH           (FLUSH),
    .REDIRECT_PC     (REDIRECT_PC),
    .BRANCH_COUNT    (BRANCH_COUNT),
    .MISPRED_COUNT   (MISPRED_COUNT)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_pred(input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
    PC_IF = pc;
    #1;
    check("predict_taken", {31'd0, PREDICT_TAKEN}, {31'd0, exp_t});
    check("predict_target", PREDICT_TARGET, exp_tgt);
  endtask

  task automatic check_counts(input int b, input int m);
    check("branch_count", 32'(BRANCH_COUNT), 32'(b));
    check("mispred_count", 32'(MISPRED_COUNT), 32'(m));
  endtask

  // Driver: present one resolution (or idle) and queue what FLUSH/REDIRECT must show next.
  task automatic set_res(input logic v, input logic [31:0] pc, input logic j, input logic t,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input logic ef, input logic [31:0] er);
    RES_VALID       = v;
    RES_PC          = pc;
    RES_IS_JUMP     = j;
    RES_TAKEN       = t;
    RES_TARGET      = tgt;
    RES_PRED_TAKEN  = pt;
    RES_PRED_TARGET = ptgt;
    exp_q.push_back({ef, er});
  endtask

  // Scoreboard: clock once, then pop and compare the registered outputs.
  task automatic clock_and_check();
    logic [32:0] e;
    @(posedge CLK);
    #1;
    RES_VALID = 1'b0;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      e = exp_q.pop_front();
      check("flush", {31'd0, FLUSH}, {31'd0, e[32]});
      check("redirect_pc", REDIRECT_PC, e[31:0]);
    end
  endtask

  task automatic res_cycle(input logic v, input logic [31:0] pc, input logic j, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                           input logic ef, input logic [31:0] er);
    set_res(v, pc, j, t, tgt, pt, ptgt, ef, er);
    clock_and_check();
  endtask

  initial begin
    logic [31:0] rpc;

    // Vector table: one resolution each, then the prediction for the same PC.
    //          pc        jmp   tkn   tgt         ptkn  ptgt        flush redir       pt    ptgt
    vecs[0]  = '{32'h100, 1'b0, 1'b1, 32'h40,  1'b0, 32'h104, 1'b1, 32'h40,  1'b1, 32'h40};
    vecs[1]  = '{32'h100, 1'b0, 1'b0, 32'h40,  1'b1, 32'h40,  1'b1, 32'h104, 1'b0, 32'h104};
    vecs[2]  = '{32'h100, 1'b0, 1'b1, 32'h40,  1'b0, 32'h104, 1'b1, 32'h40,  1'b1, 32'h40};
    vecs[3]  = '{32'h100, 1'b0, 1'b1, 32'h40,  1'b1, 32'h40,  1'b0, 32'h40,  1'b1, 32'h40};
    vecs[4]  = '{32'h100, 1'b0, 1'b0, 32'h40,  1'b1, 32'h40,  1'b1, 32'h104, 1'b1, 32'h40};
    vecs[5]  = '{32'h100, 1'b0, 1'b1, 32'h60,  1'b1, 32'h40,  1'b1, 32'h60,  1'b1, 32'h60};
    vecs[6]  = '{32'h204, 1'b0, 1'b0, 32'h300, 1'b0, 32'h208, 1'b0, 32'h60,  1'b0, 32'h208};
    vecs[7]  = '{32'h204, 1'b0, 1'b1, 32'h300, 1'b0, 32'h208, 1'b1, 32'h300, 1'b1, 32'h300};
    vecs[8]  = '{32'h100, 1'b1, 1'b1, 32'h80,  1'b1, 32'h60,  1'b1, 32'h80,  1'b1, 32'h80};
    vecs[9]  = '{32'h200, 1'b1, 1'b1, 32'h500, 1'b0, 32'h204, 1'b1, 32'h500, 1'b1, 32'h500};
    vecs[10] = '{32'h200, 1'b1, 1'b1, 32'h510, 1'b1, 32'h500, 1'b1, 32'h510, 1'b1, 32'h510};
    vecs[11] = '{32'h200, 1'b1, 1'b1, 32'h510, 1'b1, 32'h510, 1'b0, 32'h510, 1'b1, 32'h510};

    // Reset
    RESET = 1'b0;
    PC_IF = 32'h100;
    RES_VALID = 1'b0; RES_IS_JUMP = 1'b0; RES_PC = '0; RES_TAKEN = 1'b0;
    RES_TARGET = '0; RES_PRED_TAKEN = 1'b0; RES_PRED_TARGET = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    check_pred(32'h100, 1'b0, 32'h104);
    check("reset_flush", {31'd0, FLUSH}, 32'd0);
    check("reset_redirect", REDIRECT_PC, 32'd0);
    check_counts(0, 0);

    // Table-driven training/hysteresis/alias vectors
    foreach (vecs[i]) begin
      res_cycle(1'b1, vecs[i].pc, vecs[i].jump, vecs[i].taken, vecs[i].tgt,
                vecs[i].ptaken, vecs[i].ptgt, vecs[i].exp_flush, vecs[i].exp_redir);
      if (vecs[i].exp_flush)
        res_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, vecs[i].exp_redir);
      check_pred(vecs[i].pc, vecs[i].exp_pt, vecs[i].exp_ptgt);
    end
    // 0x200 replaced the 0x100 entry at the shared index.
    check_pred(32'h100, 1'b0, 32'h104);
    check_counts(12, 9);

    // Wrong-path filter, with a same-cycle lookup seeing pre-update contents.
    set_res(1'b1, 32'h204, 1'b0, 1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h208);
    check_pred(32'h204, 1'b1, 32'h300);
    clock_and_check();
    res_cycle(1'b1, 32'h204, 1'b0, 1'b1, 32'h999, 1'b0, 32'h208, 1'b0, 32'h208);
    check_pred(32'h204, 1'b0, 32'h208);
    check_counts(13, 10);

    // Address wrap on a miss.
    check_pred(32'hFFFF_FFFC, 1'b0, 32'h0);

    // Drive mispredicts at random far-away PCs until both counts saturate.
    for (int k = 0; k < 8; k++) begin
      rpc = 32'h8000_0000 | (32'($urandom_range(0, 32'h0FFF_FFFF)) << 2);
      res_cycle(1'b1, rpc, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b1, rpc + 32'd4);
      res_cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rpc + 32'd4);
    end
    check_counts(15, 15);
    res_cycle(1'b1, 32'h9000_0000, 1'b0, 1'b1, 32'h44, 1'b0, 32'h9000_0004, 1'b1, 32'h44);
    check_counts(15, 15);

    // Reset while FLUSH is high clears everything immediately.
    check("flush_before_reset", {31'd0, FLUSH}, 32'd1);
    RESET = 1'b0;
    #1;
    check("reset_mid_flush", {31'd0, FLUSH}, 32'd0);
    check("reset_mid_redirect", REDIRECT_PC, 32'd0);
    check_counts(0, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    check_pred(32'h200, 1'b0, 32'h204);
    check_pred(32'h204, 1'b0, 32'h208);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
